imem_boot_loader: RTL and testbench
===================================

// Module: imem_boot_loader
// PURPOSE
//  Upstream stage of the single-cycle core. Receives a program as a byte stream over a valid/ready link.
//  Packs the bytes into 32-bit little-endian words and writes them into the IMEM write port.
//  Holds the core in reset (core_hold) until the whole image is loaded.
//  Releases the core only after a good load; a bad image latches an error instead.
// PARAMETERS
//  ADDR_W     10    IMEM word-address width
//  MAX_WORDS  1024  largest accepted image, in words; must be <= 2**ADDR_W
// PORTS
//  clk         in   1       system clock; every register updates on the rising edge
//  rst         in   1       asynchronous active-low reset (0 = reset)
//  in_valid    in   1       a byte is offered on in_data
//  in_data     in   8       stream byte
//  in_ready    out  1       loader accepts a byte this cycle
//  imem_we     out  1       one-cycle IMEM write strobe
//  imem_addr   out  ADDR_W  IMEM word address
//  imem_wdata  out  32      IMEM write data
//  core_hold   out  1       1 = keep the core (pc/regfile) in reset
//  boot_done   out  1       image loaded, core released
//  boot_err    out  1       image rejected, core stays held
//  word_cnt    out  ADDR_W+1  number of words written so far
// BEHAVIOUR
//  Reset values: in_ready=0, imem_we=0, imem_addr=0, imem_wdata=0, core_hold=1, boot_done=0, boot_err=0, word_cnt=0.
//  Stream format, all fields little-endian:
//   - 4-byte header N = word count;
//   - then N words, 4 bytes each;
//   - then, with BOOT_CHECKSUM_EN only, a 4-byte checksum.
//  A byte is accepted only on a cycle where in_valid && in_ready.
//  States:
//   - RST -> HDR on the first clk after rst rises.
//   - HDR: in_ready=1; collect 4 bytes into N. Then: N==0 -> DONE; N>MAX_WORDS -> ERR; else -> LOAD.
//   - LOAD: in_ready=1. Each 4th byte completes a word.
//     - Next cycle: imem_we=1 for exactly one cycle, imem_addr=word_cnt[ADDR_W-1:0], imem_wdata=packed word.
//     - word_cnt increments in that same cycle.
//     - After word N completes -> CHK if BOOT_CHECKSUM_EN, else -> DONE.
//   - CHK: in_ready=1; collect 4 bytes, compare with the running checksum. Match -> DONE, else -> ERR.
//   - DONE: in_ready=0, core_hold=0, boot_done=1. Terminal until reset.
//   - ERR: in_ready=0, core_hold=1, boot_err=1. Terminal until reset.
//  Write latency is 1 cycle from acceptance of the 4th byte. in_ready stays 1 during the write cycle, so a
//   back-to-back byte is accepted while the previous word is being written.
//  The last word's write strobe and the DONE transition share a cycle; core_hold drops the cycle after imem_we.
//  Byte-lane order: first byte -> wdata[7:0], fourth byte -> wdata[31:24].
//  in_valid gaps stall assembly with no timeout; partial-word bytes are held.
//  Address never wraps: N<=MAX_WORDS is checked before LOAD is entered.
//  Reset mid-load: all state clears immediately and core_hold=1. IMEM contents already written are not erased.
//   A new image must restart from its header.
//  in_data is ignored whenever in_ready=0.
// CONFIGURATION
//  BOOT_CHECKSUM_EN defined:
//   - running XOR of all N words (initial value 0) is compared against the trailing 4-byte checksum;
//   - mismatch -> ERR.
//  BOOT_CHECKSUM_EN undefined:
//   - no CHK state and no checksum register;
//   - DONE follows the last word; boot_err is asserted only for N>MAX_WORDS.
// STRUCTURE
//  Package boot_pkg: state encoding localparams (ST_RST, ST_HDR, ST_LOAD, ST_CHK, ST_DONE, ST_ERR),
//   HDR_BYTES=4, WORD_BYTES=4.
//  Sub-module byte_packer: 2-bit lane counter + 32-bit shift register.
//   Outputs word_valid (one cycle) and word; cleared by a sync clear from the FSM at each state entry.
//  FSM, address/word counters and checksum stay in imem_boot_loader.
// TESTING
//  1. Reset, stream 02 00 00 00 | 13 05 10 00 | 93 05 20 00, in_valid held 1
//     -> writes addr0=0x00100513, addr1=0x00200593; boot_done=1 and core_hold=0 one cycle after the 2nd write.
//  2. Header N=0 -> DONE right after the 4th header byte; no imem_we pulse.
//  3. Header N=MAX_WORDS+1 (01 04 00 00) -> boot_err=1, in_ready=0, core_hold=1, no writes.
//  4. Case 1 with in_valid toggling 1,0,0,1 -> identical writes and data; in_ready never accepts a byte with in_valid=0.
//  5. Drop rst after 5 words of N=8 -> all outputs at reset values in the same cycle.
//     After release, a full re-send loads correctly from addr 0.
//  6. BOOT_CHECKSUM_EN, case 1 plus checksum 80 00 30 00 (0x00300080) -> DONE; checksum 00 00 00 00 -> ERR.

Source files
------------

// File: rtl/boot_pkg.sv
// rtl/boot_pkg.sv - state encoding and stream framing constants for the IMEM boot loader
package boot_pkg;

  typedef logic [2:0] state_t;

  localparam state_t ST_RST  = 3'd0;
  localparam state_t ST_HDR  = 3'd1;
  localparam state_t ST_LOAD = 3'd2;
  localparam state_t ST_CHK  = 3'd3;
  localparam state_t ST_DONE = 3'd4;
  localparam state_t ST_ERR  = 3'd5;

  localparam int HDR_BYTES  = 4;
  localparam int WORD_BYTES = 4;
  localparam int LANE_W     = $clog2(WORD_BYTES);

endpackage

// File: rtl/byte_packer.sv
// rtl/byte_packer.sv - packs accepted stream bytes into little-endian 32-bit words
// word/word_valid are combinational so the owner can register the write in the accepting cycle.
module byte_packer
  import boot_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        clear,
  input  logic        accept,
  input  logic [7:0]  data,
  output logic        word_valid,
  output logic [31:0] word
);

  logic [LANE_W-1:0] lane;
  logic [31:0]       shreg;

  // Newest byte enters at the top, so the first byte ends up in bits [7:0].
  assign word       = {data, shreg[31:8]};
  assign word_valid = accept && (lane == LANE_W'(WORD_BYTES - 1));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      lane  <= '0;
      shreg <= '0;
    end else if (clear) begin
      lane  <= '0;
      shreg <= '0;
    end else if (accept) begin
      lane  <= lane + 1'b1;
      shreg <= word;
    end
  end

endmodule

// File: rtl/imem_boot_loader.sv
// rtl/imem_boot_loader.sv - loads a length-prefixed byte image into IMEM and holds the core until done
// Optional trailing XOR checksum over all words when BOOT_CHECKSUM_EN is defined.
module imem_boot_loader
  import boot_pkg::*;
#(
  parameter int ADDR_W    = 10,
  parameter int MAX_WORDS = 1024
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic [7:0]        in_data,
  output logic              in_ready,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [31:0]       imem_wdata,
  output logic              core_hold,
  output logic              boot_done,
  output logic              boot_err,
  output logic [ADDR_W:0]   word_cnt
);

  localparam logic [31:0] MAX_N = 32'(MAX_WORDS);

  state_t        state, state_next;
  logic          accept, word_valid, last_word;
  logic [31:0]   word;
  logic [ADDR_W:0] n_words;
  logic          hold_d, done_d, err_d;

  assign accept    = in_valid && in_ready;
  assign last_word = ((word_cnt + (ADDR_W+1)'(1)) == n_words);

`ifdef BOOT_CHECKSUM_EN
  logic [31:0] csum;
`endif

  byte_packer u_packer (
    .clk        (clk),
    .rst        (rst),
    .clear      (state_next != state),
    .accept     (accept),
    .data       (in_data),
    .word_valid (word_valid),
    .word       (word)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= ST_RST;
    else      state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      ST_RST:  state_next = ST_HDR;
      ST_HDR:
        if (word_valid) begin
          if (word == 32'd0)     state_next = ST_DONE;
          else if (word > MAX_N) state_next = ST_ERR;
          else                   state_next = ST_LOAD;
        end
      ST_LOAD:
        if (word_valid && last_word) begin
`ifdef BOOT_CHECKSUM_EN
          state_next = ST_CHK;
`else
          state_next = ST_DONE;
`endif
        end
`ifdef BOOT_CHECKSUM_EN
      ST_CHK:
        if (word_valid) state_next = (word == csum) ? ST_DONE : ST_ERR;
`endif
      default: state_next = state;
    endcase
  end

  always_comb begin
    in_ready = (state == ST_HDR) || (state == ST_LOAD) || (state == ST_CHK);
    hold_d   = (state != ST_DONE);
    done_d   = (state == ST_DONE);
    err_d    = (state == ST_ERR);
  end

  // Status is registered so core_hold falls the cycle after the last write strobe.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      core_hold <= 1'b1;
      boot_done <= 1'b0;
      boot_err  <= 1'b0;
    end else begin
      core_hold <= hold_d;
      boot_done <= done_d;
      boot_err  <= err_d;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      imem_we    <= 1'b0;
      imem_addr  <= '0;
      imem_wdata <= '0;
      word_cnt   <= '0;
      n_words    <= '0;
    end else begin
      imem_we <= 1'b0;
      if (state == ST_HDR && word_valid) n_words <= word[ADDR_W:0];
      if (state == ST_LOAD && word_valid) begin
        imem_we    <= 1'b1;
        imem_addr  <= word_cnt[ADDR_W-1:0];
        imem_wdata <= word;
        word_cnt   <= word_cnt + 1'b1;
      end
    end
  end

`ifdef BOOT_CHECKSUM_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                           csum <= '0;
    else if (state == ST_LOAD && word_valid) csum <= csum ^ word;
  end
`endif

endmodule

// File: tb/tb_imem_boot_loader.sv
// tb/tb_imem_boot_loader.sv - scoreboard bench for imem_boot_loader
module tb_imem_boot_loader;

  localparam int ADDR_W    = 10;
  localparam int MAX_WORDS = 1024;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [31:0]       data;
  } wr_t;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic              in_valid = 1'b0;
  logic [7:0]        in_data = 8'h00;
  logic              in_ready;
  logic              imem_we;
  logic [ADDR_W-1:0] imem_addr;
  logic [31:0]       imem_wdata;
  logic              core_hold;
  logic              boot_done;
  logic              boot_err;
  logic [ADDR_W:0]   word_cnt;

  int  n_tests = 0;
  int  n_fail  = 0;
  wr_t exp_q[$];

  imem_boot_loader #(.ADDR_W(ADDR_W), .MAX_WORDS(MAX_WORDS)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_data    (in_data),
    .in_ready   (in_ready),
    .imem_we    (imem_we),
    .imem_addr  (imem_addr),
    .imem_wdata (imem_wdata),
    .core_hold  (core_hold),
    .boot_done  (boot_done),
    .boot_err   (boot_err),
    .word_cnt   (word_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Scoreboard: every write strobe must match the oldest expected write.
  always @(negedge clk) begin
    if (rst && imem_we) begin
      if (exp_q.size() == 0) begin
        check("we_unexpected", 32'd1, 32'd0);
      end else begin
        wr_t e;
        e = exp_q.pop_front();
        check("we_addr", 32'(imem_addr), 32'(e.addr));
        check("we_data", imem_wdata, e.data);
        check("we_cnt", 32'(word_cnt), 32'(e.addr) + 32'd1);
      end
    end
  end

  task automatic check_reset_values(input string tag);
    check({tag, "_in_ready"}, 32'(in_ready), 32'd0);
    check({tag, "_we"}, 32'(imem_we), 32'd0);
    check({tag, "_addr"}, 32'(imem_addr), 32'd0);
    check({tag, "_wdata"}, imem_wdata, 32'd0);
    check({tag, "_hold"}, 32'(core_hold), 32'd1);
    check({tag, "_done"}, 32'(boot_done), 32'd0);
    check({tag, "_err"}, 32'(boot_err), 32'd0);
    check({tag, "_wcnt"}, 32'(word_cnt), 32'd0);
  endtask

  task automatic do_reset();
    rst = 1'b0;
    in_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_reset_values("rst");
    rst = 1'b1;
  endtask

  // Offers one byte after `gap` idle cycles; returns just after the accepting edge.
  task automatic send_byte(input logic [7:0] b, input int gap);
    int n = 0;
    if (gap > 0) begin
      in_valid = 1'b0;
      for (int g = 0; g < gap; g++) begin
        in_data = 8'($urandom);
        @(posedge clk);
        #1;
      end
    end
    in_valid = 1'b1;
    in_data  = b;
    @(negedge clk);
    while (!in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) check("ready_timeout", 32'd0, 32'd1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_data  = 8'($urandom);
  endtask

  task automatic send_word(input logic [31:0] w, input int gap);
    for (int i = 0; i < 4; i++) send_byte(w[8*i +: 8], gap);
  endtask

  task automatic send_image(input logic [31:0] n, input logic [31:0] w[$], input int gap, input int nsend);
    send_word(n, gap);
    for (int i = 0; i < nsend; i++) begin
      exp_q.push_back('{addr: ADDR_W'(i), data: w[i]});
      send_word(w[i], gap);
    end
  endtask

  task automatic expect_done(input string tag, input int nw);
    @(negedge clk);
`ifndef BOOT_CHECKSUM_EN
    check({tag, "_last_we"}, 32'(imem_we), 32'd1);
`endif
    check({tag, "_hold_wr"}, 32'(core_hold), 32'd1);
    @(negedge clk);
    check({tag, "_done"}, 32'(boot_done), 32'd1);
    check({tag, "_hold"}, 32'(core_hold), 32'd0);
    check({tag, "_err"}, 32'(boot_err), 32'd0);
    check({tag, "_ready"}, 32'(in_ready), 32'd0);
    check({tag, "_wcnt"}, 32'(word_cnt), 32'(nw));
    check({tag, "_q_empty"}, 32'(exp_q.size()), 32'd0);
  endtask

  task automatic send_full(input string tag, input logic [31:0] w[$], input int gap);
    logic [31:0] x = 32'd0;
    send_image(32'(w.size()), w, gap, w.size());
    foreach (w[i]) x = x ^ w[i];
`ifdef BOOT_CHECKSUM_EN
    send_word(x, gap);
`endif
    expect_done(tag, w.size());
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] img1[$];
    logic [31:0] img8a[$];
    logic [31:0] img8b[$];
    img1 = '{32'h00100513, 32'h00200593};
    for (int i = 0; i < 8; i++) begin
      img8a.push_back($urandom);
      img8b.push_back($urandom);
    end

    // Case 1: two words, in_valid held high
    do_reset();
    send_full("c1", img1, 0);

    // Case 2: empty image
    do_reset();
    send_word(32'd0, 0);
    @(negedge clk);
    check("c2_ready_off", 32'(in_ready), 32'd0);
    @(negedge clk);
    check("c2_done", 32'(boot_done), 32'd1);
    check("c2_hold", 32'(core_hold), 32'd0);
    check("c2_wcnt", 32'(word_cnt), 32'd0);

    // Case 3: oversize header
    do_reset();
    send_word(32'(MAX_WORDS + 1), 0);
    @(negedge clk);
    check("c3_ready_off", 32'(in_ready), 32'd0);
    @(negedge clk);
    check("c3_err", 32'(boot_err), 32'd1);
    check("c3_hold", 32'(core_hold), 32'd1);
    check("c3_done", 32'(boot_done), 32'd0);
    check("c3_ready", 32'(in_ready), 32'd0);
    check("c3_wcnt", 32'(word_cnt), 32'd0);

    // Case 4: in_valid pattern 1,0,0,1 with garbage on in_data during gaps
    do_reset();
    send_full("c4", img1, 2);

    // Case 5: reset after 5 of 8 words, then a full re-send
    do_reset();
    send_image(32'd8, img8a, 0, 5);
    @(negedge clk);
    #2;
    rst = 1'b0;
    #1;
    check_reset_values("c5_midrst");
    check("c5_q_empty", 32'(exp_q.size()), 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b1;
    send_full("c5_reload", img8b, 0);

`ifdef BOOT_CHECKSUM_EN
    // Case 6: explicit known checksum, then a wrong one
    do_reset();
    send_image(32'd2, img1, 0, 2);
    send_word(32'h00300080, 0);
    expect_done("c6_good", 2);
    do_reset();
    send_image(32'd2, img1, 0, 2);
    send_word(32'h00000000, 0);
    repeat (2) @(negedge clk);
    check("c6_bad_err", 32'(boot_err), 32'd1);
    check("c6_bad_hold", 32'(core_hold), 32'd1);
    check("c6_bad_done", 32'(boot_done), 32'd0);
`endif

    repeat (3) @(negedge clk);
    check("end_q_empty", 32'(exp_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
